// File: rtl/saturn_bus_arbiter.sv
// rtl/saturn_bus_arbiter.sv - shares the Saturn bus controller among fetch, data and system requesters
// Fetch is the background owner; data/sys preempt it and the fetch PC is restored with LOAD_PC afterwards.
module saturn_bus_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int LEN_W   = 4,
  parameter int TMO_MAX = 63
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_fetch_req,
  input  logic              i_fetch_jump,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_gnt,
  input  logic              i_data_req,
  input  logic              i_data_we,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [LEN_W-1:0]  i_data_len,
  output logic              o_data_gnt,
  output logic              o_data_done,
  input  logic              i_sys_req,
  input  logic              i_sys_op,
  input  logic [ADDR_W-1:0] i_sys_addr,
  output logic              o_sys_gnt,
  output logic              o_sys_done,
  output logic              o_load_pc,
  output logic              o_cmd_load_dp,
  output logic              o_cmd_dp_write,
  output logic              o_cmd_config,
  output logic              o_cmd_reset,
  output logic [ADDR_W-1:0] o_address,
  input  logic              i_bus_stalled,
  input  logic              i_nib_strobe,
  output logic              o_error,
  output logic [1:0]        o_owner
);

  localparam int TW = $clog2(TMO_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DATA_ADDR,
    S_DATA_XFER,
    S_SYS_WAIT,
    S_SYS_END,
    S_RESTORE_PC
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                pc_valid_q;
  logic [TW-1:0]       tmo_q;
  logic                seen_q;
  logic                sent_q;
  logic                we_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;
  logic                fetch_gnt_q;
  logic                data_gnt_q;
  logic                data_done_q;
  logic                sys_gnt_q;
  logic                sys_done_q;
  logic                load_pc_q;
  logic                load_dp_q;
  logic                dp_write_q;
  logic                config_q;
  logic                reset_q;
  logic [ADDR_W-1:0]   address_q;
  logic                error_q;
  logic [1:0]          owner_q;

  logic waiting;
  logic tmo_hit;
  logic stall_fall;
  logic arb_ok;

  assign waiting    = (state_q == S_DATA_ADDR) || (state_q == S_DATA_XFER) ||
                      (state_q == S_SYS_WAIT)  || (state_q == S_RESTORE_PC);
  assign tmo_hit    = waiting && (tmo_q == TW'(TMO_MAX - 1));
  // seen_q remembers that the controller went busy, so a low level afterwards is its falling edge
  assign stall_fall = seen_q && !i_bus_stalled;
  // fetch is only interrupted between nibbles
  assign arb_ok     = (state_q == S_IDLE) || !i_nib_strobe;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      pc_valid_q  <= 1'b0;
      tmo_q       <= '0;
      seen_q      <= 1'b0;
      sent_q      <= 1'b0;
      we_q        <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      fetch_gnt_q <= 1'b0;
      data_gnt_q  <= 1'b0;
      data_done_q <= 1'b0;
      sys_gnt_q   <= 1'b0;
      sys_done_q  <= 1'b0;
      load_pc_q   <= 1'b0;
      load_dp_q   <= 1'b0;
      dp_write_q  <= 1'b0;
      config_q    <= 1'b0;
      reset_q     <= 1'b0;
      address_q   <= '0;
      error_q     <= 1'b0;
      owner_q     <= 2'd0;
    end else begin
      load_pc_q   <= 1'b0;
      load_dp_q   <= 1'b0;
      data_done_q <= 1'b0;
      sys_done_q  <= 1'b0;
      if (tmo_hit) begin
        // abort: complete the pending handshake so the requester is not left hanging
        error_q     <= 1'b1;
        data_done_q <= (state_q == S_DATA_ADDR) || (state_q == S_DATA_XFER);
        sys_done_q  <= (state_q == S_SYS_WAIT);
        dp_write_q  <= 1'b0;
        config_q    <= 1'b0;
        reset_q     <= 1'b0;
        fetch_gnt_q <= 1'b0;
        data_gnt_q  <= 1'b0;
        sys_gnt_q   <= 1'b0;
        owner_q     <= 2'd0;
        pc_valid_q  <= 1'b0;
        seen_q      <= 1'b0;
        sent_q      <= 1'b0;
        tmo_q       <= '0;
        state_q     <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE, S_FETCH: begin
            if (state_q == S_FETCH && i_nib_strobe) begin
              pc_q <= pc_q + ADDR_W'(1);
            end
            if (state_q == S_FETCH && i_fetch_req && i_fetch_jump) begin
              pc_q       <= i_fetch_addr;
              pc_valid_q <= 1'b1;
              load_pc_q  <= 1'b1;
              address_q  <= i_fetch_addr;
            end else if (arb_ok && i_sys_req) begin
              state_q     <= S_SYS_WAIT;
              fetch_gnt_q <= 1'b0;
              sys_gnt_q   <= 1'b1;
              owner_q     <= 2'd3;
              config_q    <= !i_sys_op;
              reset_q     <= i_sys_op;
              address_q   <= i_sys_addr;
              if (i_sys_op) begin
                pc_valid_q <= 1'b0;
              end
              seen_q      <= 1'b0;
              tmo_q       <= '0;
            end else if (arb_ok && i_data_req) begin
              state_q     <= S_DATA_ADDR;
              fetch_gnt_q <= 1'b0;
              data_gnt_q  <= 1'b1;
              owner_q     <= 2'd2;
              load_dp_q   <= 1'b1;
              address_q   <= i_data_addr;
              we_q        <= i_data_we;
              len_q       <= i_data_len;
              seen_q      <= 1'b0;
              tmo_q       <= '0;
            end else if (i_fetch_req && (i_fetch_jump || pc_valid_q)) begin
              state_q     <= S_FETCH;
              fetch_gnt_q <= 1'b1;
              owner_q     <= 2'd1;
              if (i_fetch_jump) begin
                pc_q       <= i_fetch_addr;
                pc_valid_q <= 1'b1;
                load_pc_q  <= 1'b1;
                address_q  <= i_fetch_addr;
              end
            end else begin
              state_q     <= S_IDLE;
              fetch_gnt_q <= 1'b0;
              owner_q     <= 2'd0;
            end
          end

          S_DATA_ADDR: begin
            if (stall_fall) begin
              state_q    <= S_DATA_XFER;
              dp_write_q <= we_q;
              cnt_q      <= '0;
              seen_q     <= 1'b0;
              tmo_q      <= '0;
            end else begin
              seen_q <= seen_q || i_bus_stalled;
              tmo_q  <= tmo_q + TW'(1);
            end
          end

          S_DATA_XFER: begin
            if (i_nib_strobe && cnt_q == len_q) begin
              state_q     <= S_RESTORE_PC;
              data_done_q <= 1'b1;
              data_gnt_q  <= 1'b0;
              owner_q     <= 2'd0;
              dp_write_q  <= 1'b0;
              sent_q      <= 1'b0;
              seen_q      <= 1'b0;
              tmo_q       <= '0;
            end else begin
              if (i_nib_strobe) begin
                cnt_q <= cnt_q + LEN_W'(1);
              end
              tmo_q <= tmo_q + TW'(1);
            end
          end

          S_SYS_WAIT: begin
            if (stall_fall) begin
              state_q    <= S_SYS_END;
              config_q   <= 1'b0;
              reset_q    <= 1'b0;
              sys_done_q <= 1'b1;
              seen_q     <= 1'b0;
              tmo_q      <= '0;
            end else begin
              seen_q <= seen_q || i_bus_stalled;
              tmo_q  <= tmo_q + TW'(1);
            end
          end

          S_SYS_END: begin
            state_q   <= S_RESTORE_PC;
            sys_gnt_q <= 1'b0;
            owner_q   <= 2'd0;
            sent_q    <= 1'b0;
            seen_q    <= 1'b0;
            tmo_q     <= '0;
          end

          S_RESTORE_PC: begin
            if (!pc_valid_q) begin
              state_q <= S_IDLE;
              tmo_q   <= '0;
            end else if (!sent_q) begin
              load_pc_q <= 1'b1;
              address_q <= pc_q;
              sent_q    <= 1'b1;
              tmo_q     <= tmo_q + TW'(1);
            end else if (stall_fall) begin
              state_q <= S_IDLE;
              seen_q  <= 1'b0;
              sent_q  <= 1'b0;
              tmo_q   <= '0;
            end else begin
              seen_q <= seen_q || i_bus_stalled;
              tmo_q  <= tmo_q + TW'(1);
            end
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_fetch_gnt    = fetch_gnt_q;
  assign o_data_gnt     = data_gnt_q;
  assign o_data_done    = data_done_q;
  assign o_sys_gnt      = sys_gnt_q;
  assign o_sys_done     = sys_done_q;
  assign o_load_pc      = load_pc_q;
  assign o_cmd_load_dp  = load_dp_q;
  assign o_cmd_dp_write = dp_write_q;
  assign o_cmd_config   = config_q;
  assign o_cmd_reset    = reset_q;
  assign o_address      = address_q;
  assign o_error        = error_q;
  assign o_owner        = owner_q;

endmodule

// File: tb/tb_saturn_bus_arbiter.sv
// tb/tb_saturn_bus_arbiter.sv - scoreboard bench for saturn_bus_arbiter
module tb_saturn_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0, fetch_jump = 1'b0;
  logic [19:0] fetch_addr = '0;
  logic        data_req = 1'b0, data_we = 1'b0;
  logic [19:0] data_addr = '0;
  logic [3:0]  data_len = '0;
  logic        sys_req = 1'b0, sys_op = 1'b0;
  logic [19:0] sys_addr = '0;
  logic        stall = 1'b0, nib = 1'b0;
  logic        fetch_gnt, data_gnt, data_done, sys_gnt, sys_done;
  logic        load_pc, load_dp, dp_write, cmd_cfg, cmd_rst, err;
  logic [19:0] address;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  saturn_bus_arbiter #(.ADDR_W(20), .LEN_W(4), .TMO_MAX(63)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_fetch_req(fetch_req), .i_fetch_jump(fetch_jump), .i_fetch_addr(fetch_addr), .o_fetch_gnt(fetch_gnt),
    .i_data_req(data_req), .i_data_we(data_we), .i_data_addr(data_addr), .i_data_len(data_len),
    .o_data_gnt(data_gnt), .o_data_done(data_done),
    .i_sys_req(sys_req), .i_sys_op(sys_op), .i_sys_addr(sys_addr), .o_sys_gnt(sys_gnt), .o_sys_done(sys_done),
    .o_load_pc(load_pc), .o_cmd_load_dp(load_dp), .o_cmd_dp_write(dp_write),
    .o_cmd_config(cmd_cfg), .o_cmd_reset(cmd_rst), .o_address(address),
    .i_bus_stalled(stall), .i_nib_strobe(nib), .o_error(err), .o_owner(owner)
  );

  // event kinds: 1 LOAD_PC, 2 LOAD_DP, 3 CONFIG rise, 4 RESET rise, 5 DP_WRITE rise,
  // 6 DP_WRITE fall, 7 DATA_DONE, 8 SYS_DONE, 9 ERROR rise
  typedef struct {
    int          kind;
    logic [19:0] addr;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [19:0] addr);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input logic [19:0] addr);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event actual=kind%0d/%0h required=none t=%0t", kind, addr, $time);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("ev_kind(exp %0d)", e.kind), kind, e.kind);
      chk($sformatf("ev_addr(kind %0d)", e.kind), addr, e.addr);
    end
  endtask

  // monitor: turns DUT output activity into events and checks the cycle invariants
  logic prev_dpw = 1'b0, prev_cfg = 1'b0, prev_rst = 1'b0, prev_err = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dpw = 1'b0; prev_cfg = 1'b0; prev_rst = 1'b0; prev_err = 1'b0;
    end else begin
      if (load_pc)               got(1, address);
      if (load_dp)               got(2, address);
      if (cmd_cfg && !prev_cfg)  got(3, address);
      if (cmd_rst && !prev_rst)  got(4, 20'h0);
      if (dp_write && !prev_dpw) got(5, 20'h0);
      if (!dp_write && prev_dpw) got(6, 20'h0);
      if (data_done)             got(7, 20'h0);
      if (sys_done)              got(8, 20'h0);
      if (err && !prev_err)      got(9, 20'h0);
      chk("cmd_onehot", 32'(int'(load_pc) + int'(load_dp) + int'(cmd_cfg) + int'(cmd_rst) <= 1), 32'd1);
      chk("grant_onehot", 32'(int'(fetch_gnt) + int'(data_gnt) + int'(sys_gnt) <= 1), 32'd1);
      chk("owner_vs_grant", owner, fetch_gnt ? 2'd1 : data_gnt ? 2'd2 : sys_gnt ? 2'd3 : 2'd0);
      prev_dpw = dp_write; prev_cfg = cmd_cfg; prev_rst = cmd_rst; prev_err = err;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outputs"},
        {fetch_gnt, data_gnt, data_done, sys_gnt, sys_done, load_pc, load_dp,
         dp_write, cmd_cfg, cmd_rst, err, owner}, 32'd0);
    chk({tag, "_address"}, address, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // fetch jump then 5 nibbles, preempted by a 2-nibble read
    fetch_req = 1'b1; fetch_jump = 1'b1; fetch_addr = 20'h00100;
    expect_ev(1, 20'h00100);
    tick();
    fetch_jump = 1'b0;
    chk("t1_fetch_owner", owner, 2'd1);
    nib = 1'b1; tick(5); nib = 1'b0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 20'h02000; data_len = 4'd1;
    expect_ev(2, 20'h02000);
    tick();
    stall = 1'b1; tick(2); stall = 1'b0; tick();
    expect_ev(7, 20'h0);
    nib = 1'b1; tick(2); nib = 1'b0; data_req = 1'b0;
    expect_ev(1, 20'h00105);
    tick(); stall = 1'b1; tick(); stall = 1'b0; tick();
    tick();
    chk("t1_refetch_gnt", fetch_gnt, 1'b1);

    // write of 4 nibbles after a 6-cycle stall
    data_req = 1'b1; data_we = 1'b1; data_addr = 20'h80000; data_len = 4'd3;
    expect_ev(2, 20'h80000);
    expect_ev(5, 20'h0);
    tick();
    stall = 1'b1; tick(6);
    chk("t2_dpw_before_xfer", dp_write, 1'b0);
    stall = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      nib = 1'b1;
      chk($sformatf("t2_dpw_strobe%0d", i), dp_write, 1'b1);
      if (i == 3) begin
        expect_ev(6, 20'h0);
        expect_ev(7, 20'h0);
      end
      tick();
    end
    nib = 1'b0; data_req = 1'b0;
    chk("t2_dpw_after_xfer", dp_write, 1'b0);
    expect_ev(1, 20'h00105);
    tick(); stall = 1'b1; tick(); stall = 1'b0; tick();
    tick();

    // simultaneous sys CONFIGURE and data read from IDLE: sys first
    fetch_req = 1'b0; tick();
    chk("t3_idle_owner", owner, 2'd0);
    sys_req = 1'b1; sys_op = 1'b0; sys_addr = 20'hF0000;
    data_req = 1'b1; data_we = 1'b0; data_addr = 20'h12345; data_len = 4'd0;
    expect_ev(3, 20'hF0000);
    expect_ev(8, 20'h0);
    expect_ev(1, 20'h00105);
    expect_ev(2, 20'h12345);
    expect_ev(7, 20'h0);
    expect_ev(1, 20'h00105);
    tick();
    chk("t3_sys_first", {sys_gnt, data_gnt}, 2'b10);
    stall = 1'b1; tick(); stall = 1'b0; tick();
    sys_req = 1'b0;
    tick(); tick();
    stall = 1'b1; tick(); stall = 1'b0; tick();
    tick();
    chk("t3_data_after", data_gnt, 1'b1);
    stall = 1'b1; tick(); stall = 1'b0; tick();
    nib = 1'b1; tick(); nib = 1'b0; data_req = 1'b0;
    tick(); stall = 1'b1; tick(); stall = 1'b0; tick();
    tick();

    // RESET op: command held until stall falls, then no LOAD_PC
    sys_req = 1'b1; sys_op = 1'b1; sys_addr = 20'h0;
    expect_ev(4, 20'h0);
    expect_ev(8, 20'h0);
    tick(3);
    chk("t4_reset_held", cmd_rst, 1'b1);
    stall = 1'b1; tick(); stall = 1'b0; tick();
    sys_req = 1'b0;
    tick(3);
    fetch_req = 1'b1; tick(3);
    chk("t4_no_refetch", fetch_gnt, 1'b0);
    fetch_req = 1'b0; tick();

    // stall stuck high in DATA_ADDR -> timeout abort
    data_req = 1'b1; data_we = 1'b0; data_addr = 20'h00ABC; data_len = 4'd2; stall = 1'b1;
    expect_ev(2, 20'h00ABC);
    expect_ev(7, 20'h0);
    expect_ev(9, 20'h0);
    tick();
    n = 0;
    while (!err && n < 100) begin
      tick();
      n++;
    end
    chk("t5_tmo_cycles", n, 63);
    chk("t5_idle_after_abort", {data_gnt, owner}, 3'b000);
    data_req = 1'b0; stall = 1'b0;
    tick(3);
    chk("t5_error_sticky", err, 1'b1);

    // reset mid DATA_XFER
    fetch_req = 1'b1; fetch_jump = 1'b1; fetch_addr = 20'h00200;
    expect_ev(1, 20'h00200);
    tick();
    fetch_jump = 1'b0;
    nib = 1'b1; tick(2); nib = 1'b0;
    data_req = 1'b1; data_we = 1'b1; data_addr = 20'h00300; data_len = 4'd5;
    expect_ev(2, 20'h00300);
    expect_ev(5, 20'h0);
    tick();
    stall = 1'b1; tick(); stall = 1'b0; tick();
    nib = 1'b1; tick(2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async_reset");
    chk("t6_no_pending_events", exp_q.size(), 0);
    nib = 1'b0; data_req = 1'b0; fetch_req = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    fetch_req = 1'b1; fetch_jump = 1'b1; fetch_addr = 20'h00400;
    expect_ev(1, 20'h00400);
    tick();
    fetch_jump = 1'b0;
    chk("t6_restart_gnt", {fetch_gnt, owner}, 3'b101);
    nib = 1'b1; tick(3); nib = 1'b0;
    fetch_req = 1'b0;
    tick(3);
    chk("t6_final_owner", owner, 2'd0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
